mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter XLEN, default 32, SHALL set data and address width.
REQ-002 Parameter DEPTH_LOG2, default 10, SHALL set storage depth to 2^DEPTH_LOG2 words.
REQ-003 Parameter LATENCY, default 2, range 0..15, SHALL set the number of wait cycles between acceptance and response.
REQ-004 clock_in  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset_in  input  1  SHALL be a synchronous, active-high reset.
REQ-006 mem_valid_in  input  1  SHALL be the request valid from the initiator; held until the ready pulse.
REQ-007 mem_write_in  input  1  SHALL select the operation: 1 = write, 0 = read.
REQ-008 mem_addr_in  input  XLEN  SHALL carry the byte address of the request.
REQ-009 mem_data_in  input  XLEN  SHALL carry the write data.
REQ-010 mem_ready_out  output  1  SHALL be a one-cycle response pulse, registered.
REQ-011 mem_data_out  output  XLEN  SHALL carry the read response data, registered.
REQ-012 mem_error_out  output  1  SHALL flag a rejected request; valid only while mem_ready_out=1.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-014 In IDLE with mem_valid_in=1, the block SHALL capture write, addr and data into internal registers and load the counter with LATENCY.
- LATENCY=0: next state RESP.
- Otherwise: next state WAIT.
REQ-015 In WAIT the counter SHALL decrement each cycle; the transition to RESP SHALL occur on the edge where the counter equals 1.
REQ-016 mem_ready_out SHALL be 1 exactly during RESP, so a request sampled in cycle T is answered in cycle T+1+LATENCY.
REQ-017 RESP SHALL always transition to IDLE; mem_ready_out SHALL never be high in two consecutive cycles.
REQ-018 If mem_valid_in is still 1 in the IDLE cycle after RESP, it SHALL be accepted as a new request (back-to-back period = LATENCY+2 cycles).
REQ-019 A request SHALL be an error when addr[1:0]!=0, or when addr[XLEN-1:DEPTH_LOG2+2] is nonzero.
REQ-020 On the edge entering RESP:
- Valid write: storage[addr[DEPTH_LOG2+1:2]] SHALL be written with the captured data, and mem_data_out SHALL load 0.
- Valid read: mem_data_out SHALL load storage[addr[DEPTH_LOG2+1:2]].
- Error: storage SHALL be unchanged, mem_data_out SHALL load 0, and mem_error_out SHALL be 1 during RESP.
REQ-021 mem_error_out SHALL be 0 in all cycles outside RESP.
REQ-022 mem_data_out SHALL hold its last loaded value until the next RESP.
REQ-023 Input changes after acceptance, including mem_valid_in falling during WAIT, SHALL be ignored; the captured transaction SHALL complete.
REQ-024 mem_valid_in=0 in IDLE SHALL leave all state unchanged.
REQ-025 A read following a write to the same address SHALL return the written data.

Reset
REQ-026 reset_in=1 SHALL force state to IDLE, counter to 0, mem_ready_out to 0, mem_error_out to 0 and mem_data_out to 0, overriding all other events.
REQ-027 Reset asserted in WAIT SHALL abort the transaction with no storage write and no ready pulse.
REQ-028 Reset asserted in RESP SHALL take effect at the end of that cycle; the write committed on RESP entry SHALL remain.
REQ-029 Storage contents SHALL NOT be cleared by reset.
REQ-030 After reset deasserts, a request with mem_valid_in=1 SHALL be accepted in the first IDLE cycle.

Verification
REQ-031 LATENCY=2: write addr 0x10, data 0xDEADBEEF at cycle T -> ready=1 at T+3, error=0; read of 0x10 -> ready at T'+3 with data=0xDEADBEEF.
REQ-032 LATENCY=0: read with valid held continuously -> ready pulses every 2 cycles, never two consecutive cycles.
REQ-033 Misaligned read at 0x13, and write at 0x1000 with DEPTH_LOG2=10 -> ready with error=1 and data=0; a subsequent read of 0x1000&0xFFC content is unchanged.
REQ-034 Reset asserted in WAIT of a write to 0x20 (data 0x5) -> no ready pulse; a later read of 0x20 returns the prior value.
REQ-035 valid dropped after one cycle, with addr changed to 0x40 during WAIT -> response still issued for the original address.
REQ-036 Back-to-back write 0x8=0xA5A5A5A5 then read 0x8 with no idle gap -> second ready arrives LATENCY+2 cycles after the first, with data=0xA5A5A5A5.

Source files
------------

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between an initiator and mem_responder.
`default_nettype none

interface mem_responder_if #(
    parameter int XLEN = 32
);
    logic            mem_valid_in;
    logic            mem_write_in;
    logic [XLEN-1:0] mem_addr_in;
    logic [XLEN-1:0] mem_data_in;
    logic            mem_ready_out;
    logic [XLEN-1:0] mem_data_out;
    logic            mem_error_out;

    modport master (
        output mem_valid_in, mem_write_in, mem_addr_in, mem_data_in,
        input  mem_ready_out, mem_data_out, mem_error_out
    );

    modport slave (
        input  mem_valid_in, mem_write_in, mem_addr_in, mem_data_in,
        output mem_ready_out, mem_data_out, mem_error_out
    );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
//------------------------------------------------------------------------------
// mem_responder : single-outstanding word memory with fixed response latency
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_responder #(
    parameter int XLEN       = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  wire logic        clock_in,
    input  wire logic        reset_in,
    mem_responder_if.slave   bus
);
    localparam int         C_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [3:0] C_LATENCY = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  w_enter_resp;

    logic                  r_wr;
    logic [XLEN-1:0]       r_addr;
    logic [XLEN-1:0]       r_wdata;

    logic                  r_ready;
    logic                  r_err;
    logic [XLEN-1:0]       r_rdata;

    logic [XLEN-1:0]       r_mem [C_DEPTH];

    logic                  w_accept;
    logic                  w_txn_wr;
    logic [XLEN-1:0]       w_txn_addr;
    logic [XLEN-1:0]       w_txn_data;
    logic                  w_txn_err;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign w_accept = (r_state == S_IDLE) && bus.mem_valid_in;

    // With zero latency RESP is entered on the accepting edge, before the
    // capture registers hold the request, so take it straight from the bus.
    always_comb begin
        w_txn_wr   = r_wr;
        w_txn_addr = r_addr;
        w_txn_data = r_wdata;
        if (r_state == S_IDLE) begin
            w_txn_wr   = bus.mem_write_in;
            w_txn_addr = bus.mem_addr_in;
            w_txn_data = bus.mem_data_in;
        end
    end

    assign w_txn_err = (w_txn_addr[1:0] != 2'b00) ||
                       ((w_txn_addr >> (DEPTH_LOG2 + 2)) != '0);
    assign w_idx     = w_txn_addr[DEPTH_LOG2+1:2];

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.mem_valid_in) begin
                    w_cnt_nxt = C_LATENCY;
                    if (C_LATENCY == 4'd0) begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_wr    <= bus.mem_write_in;
            r_addr  <= bus.mem_addr_in;
            r_wdata <= bus.mem_data_in;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_enter_resp;
            r_err   <= w_enter_resp && w_txn_err;
            if (w_enter_resp) begin
                r_rdata <= (w_txn_err || w_txn_wr) ? '0 : r_mem[w_idx];
            end
        end
    end

    // Storage is never cleared; reset only blocks a pending commit.
    always_ff @(posedge clock_in) begin
        if (!reset_in && w_enter_resp && w_txn_wr && !w_txn_err) begin
            r_mem[w_idx] <= w_txn_data;
        end
    end

    assign bus.mem_ready_out = r_ready;
    assign bus.mem_error_out = r_err;
    assign bus.mem_data_out  = r_rdata;

endmodule

`default_nettype wire
